// File: rtl/midi_parser.sv
// midi_parser: byte-level MIDI channel-voice decoder feeding the nco.
// Tracks running status and applies monophonic last-note-priority gating.
// NOTE_NUM/NOTE_VEL/PROGRAM/GATE/NOTE_STB are all registered.
module midi_parser #(
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic [6:0] NOTE_NUM,
    output logic [6:0] NOTE_VEL,
    output logic [6:0] PROGRAM,
    output logic       GATE,
    output logic       NOTE_STB
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    localparam logic [3:0] CHAN_SEL = CHANNEL[3:0];
    localparam logic       OMNI_EN  = (OMNI != 0);

    // Status nibbles whose messages carry two data bytes
    function automatic logic two_data_f(input logic [3:0] status);
        logic two_s;
        case (status)
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: two_s = 1'b1;
            default:                      two_s = 1'b0;
        endcase
        return two_s;
    endfunction

    state_t     state_r,     state_s;
    logic [3:0] status_r,    status_s;
    logic [3:0] chan_r,      chan_s;
    logic [6:0] d1_r,        d1_s;
    logic [6:0] note_num_r,  note_num_s;
    logic [6:0] note_vel_r,  note_vel_s;
    logic [6:0] program_r,   program_s;
    logic       gate_r,      gate_s;
    logic       note_stb_r,  note_stb_s;

    logic       accept_s;
    logic       exec_s;
    logic       chan_ok_s;
    logic [6:0] ex_d1_s;
    logic [6:0] ex_d2_s;

    assign accept_s  = CE & RX_VALID;
    assign chan_ok_s = OMNI_EN | (chan_r == CHAN_SEL);

    // State and output registers; everything holds while CE is low except
    // the note strobe, which is forced back to zero so it never stretches.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= IDLE;
            status_r   <= 4'h0;
            chan_r     <= 4'h0;
            d1_r       <= 7'h00;
            note_num_r <= 7'h00;
            note_vel_r <= 7'h00;
            program_r  <= 7'h00;
            gate_r     <= 1'b0;
            note_stb_r <= 1'b0;
        end else if (CE) begin
            state_r    <= state_s;
            status_r   <= status_s;
            chan_r     <= chan_s;
            d1_r       <= d1_s;
            note_num_r <= note_num_s;
            note_vel_r <= note_vel_s;
            program_r  <= program_s;
            gate_r     <= gate_s;
            note_stb_r <= note_stb_s;
        end else begin
            note_stb_r <= 1'b0;
        end
    end

    // Byte classification, running-status sequencing and message execution
    always_comb begin
        state_s    = state_r;
        status_s   = status_r;
        chan_s     = chan_r;
        d1_s       = d1_r;
        note_num_s = note_num_r;
        note_vel_s = note_vel_r;
        program_s  = program_r;
        gate_s     = gate_r;
        note_stb_s = 1'b0;
        exec_s     = 1'b0;
        ex_d1_s    = 7'h00;
        ex_d2_s    = 7'h00;

        if (accept_s) begin
            if (RX_DATA[7:3] == 5'b11111) begin
                // Realtime: invisible to the parser, even mid-message
                state_s = state_r;
            end else if (RX_DATA[7:4] == 4'hF) begin
                // System common: kills running status
                state_s  = IDLE;
                status_s = 4'h0;
            end else if (RX_DATA[7]) begin
                // Channel status: starts a new message, aborting any partial one
                state_s  = WAIT_D1;
                status_s = RX_DATA[7:4];
                chan_s   = RX_DATA[3:0];
            end else begin
                case (state_r)
                    IDLE: begin
                        state_s = IDLE;
                    end
                    WAIT_D1: begin
                        if (two_data_f(status_r)) begin
                            d1_s    = RX_DATA[6:0];
                            state_s = WAIT_D2;
                        end else begin
                            exec_s  = 1'b1;
                            ex_d1_s = RX_DATA[6:0];
                            state_s = WAIT_D1;
                        end
                    end
                    WAIT_D2: begin
                        exec_s  = 1'b1;
                        ex_d1_s = d1_r;
                        ex_d2_s = RX_DATA[6:0];
                        state_s = WAIT_D1;
                    end
                    default: begin
                        state_s = IDLE;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end

        if (exec_s && chan_ok_s) begin
            case (status_r)
                4'h9: begin
                    if (ex_d2_s != 7'h00) begin
                        note_num_s = ex_d1_s;
                        note_vel_s = ex_d2_s;
                        gate_s     = 1'b1;
                        note_stb_s = 1'b1;
                    end else if (gate_r && (ex_d1_s == note_num_r)) begin
                        gate_s = 1'b0;
                    end else begin
                        gate_s = gate_r;
                    end
                end
                4'h8: begin
                    // Only releasing the sounding note closes the gate
                    if (gate_r && (ex_d1_s == note_num_r)) begin
                        gate_s = 1'b0;
                    end else begin
                        gate_s = gate_r;
                    end
                end
                4'hC: begin
                    program_s = ex_d1_s;
                end
                default: begin
                    gate_s = gate_r;
                end
            endcase
        end else begin
            gate_s = gate_r;
        end
    end

    assign NOTE_NUM = note_num_r;
    assign NOTE_VEL = note_vel_r;
    assign PROGRAM  = program_r;
    assign GATE     = gate_r;
    assign NOTE_STB = note_stb_r;

endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser: directed test of midi_parser (channel 0 instance plus an
// OMNI instance sharing the same byte stream).
module tb_midi_parser;

    logic       CLK;
    logic       RST;
    logic       CE;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic [6:0] NOTE_NUM, NOTE_VEL, PROGRAM;
    logic       GATE, NOTE_STB;
    logic [6:0] o_num, o_vel, o_prog;
    logic       o_gate, o_stb;

    int total;
    int bad;
    int stb_cycles;
    int snap;

    midi_parser #(.CHANNEL(0), .OMNI(0)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .NOTE_NUM(NOTE_NUM), .NOTE_VEL(NOTE_VEL), .PROGRAM(PROGRAM),
        .GATE(GATE), .NOTE_STB(NOTE_STB)
    );

    midi_parser #(.CHANNEL(0), .OMNI(1)) dut_omni (
        .CLK(CLK), .RST(RST), .CE(CE), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .NOTE_NUM(o_num), .NOTE_VEL(o_vel), .PROGRAM(o_prog),
        .GATE(o_gate), .NOTE_STB(o_stb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count cycles on which the channel-0 strobe is high
    always @(negedge CLK) begin
        if (NOTE_STB === 1'b1) stb_cycles = stb_cycles + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One byte strobe; returns 1 ns after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        tick();
        total++; if (NOTE_NUM !== 7'h00) begin bad++; $display("FAIL rst_num got=%h want=%h", NOTE_NUM, 7'h00); end
        total++; if (NOTE_VEL !== 7'h00) begin bad++; $display("FAIL rst_vel got=%h want=%h", NOTE_VEL, 7'h00); end
        total++; if (PROGRAM !== 7'h00) begin bad++; $display("FAIL rst_prog got=%h want=%h", PROGRAM, 7'h00); end
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL rst_gate got=%b want=%b", GATE, 1'b0); end
        total++; if (NOTE_STB !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b want=%b", NOTE_STB, 1'b0); end
    endtask

    task automatic test_note_on();
        snap = stb_cycles;
        send_byte(8'h90);
        send_byte(8'h3C);
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL on_gate_early got=%b want=%b", GATE, 1'b0); end
        send_byte(8'h64);
        total++; if (NOTE_NUM !== 7'h3C) begin bad++; $display("FAIL on_num got=%h want=%h", NOTE_NUM, 7'h3C); end
        total++; if (NOTE_VEL !== 7'h64) begin bad++; $display("FAIL on_vel got=%h want=%h", NOTE_VEL, 7'h64); end
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL on_gate got=%b want=%b", GATE, 1'b1); end
        total++; if (NOTE_STB !== 1'b1) begin bad++; $display("FAIL on_stb got=%b want=%b", NOTE_STB, 1'b1); end
        tick();
        total++; if (NOTE_STB !== 1'b0) begin bad++; $display("FAIL on_stb_drop got=%b want=%b", NOTE_STB, 1'b0); end
        tick();
        total++; if (stb_cycles - snap !== 1) begin bad++; $display("FAIL on_stb_width got=%0d want=%0d", stb_cycles - snap, 1); end
    endtask

    task automatic test_running_status();
        send_byte(8'h40);
        send_byte(8'h50);
        total++; if (NOTE_NUM !== 7'h40) begin bad++; $display("FAIL rs_num got=%h want=%h", NOTE_NUM, 7'h40); end
        total++; if (NOTE_VEL !== 7'h50) begin bad++; $display("FAIL rs_vel got=%h want=%h", NOTE_VEL, 7'h50); end
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL rs_gate got=%b want=%b", GATE, 1'b1); end
        total++; if (NOTE_STB !== 1'b1) begin bad++; $display("FAIL rs_stb got=%b want=%b", NOTE_STB, 1'b1); end
        send_byte(8'h40);
        send_byte(8'h00);
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL rs_off_gate got=%b want=%b", GATE, 1'b0); end
        total++; if (NOTE_NUM !== 7'h40) begin bad++; $display("FAIL rs_off_num got=%h want=%h", NOTE_NUM, 7'h40); end
        total++; if (NOTE_VEL !== 7'h50) begin bad++; $display("FAIL rs_off_vel got=%h want=%h", NOTE_VEL, 7'h50); end
        total++; if (NOTE_STB !== 1'b0) begin bad++; $display("FAIL rs_off_stb got=%b want=%b", NOTE_STB, 1'b0); end
    endtask

    task automatic test_last_note();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h7F);
        send_byte(8'h90); send_byte(8'h43); send_byte(8'h20);
        total++; if (NOTE_NUM !== 7'h43) begin bad++; $display("FAIL ln_num got=%h want=%h", NOTE_NUM, 7'h43); end
        total++; if (NOTE_VEL !== 7'h20) begin bad++; $display("FAIL ln_vel got=%h want=%h", NOTE_VEL, 7'h20); end
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL ln_stale_off_gate got=%b want=%b", GATE, 1'b1); end
        total++; if (NOTE_NUM !== 7'h43) begin bad++; $display("FAIL ln_stale_off_num got=%h want=%h", NOTE_NUM, 7'h43); end
        send_byte(8'h80); send_byte(8'h43); send_byte(8'h00);
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL ln_off_gate got=%b want=%b", GATE, 1'b0); end
        total++; if (NOTE_NUM !== 7'h43) begin bad++; $display("FAIL ln_off_num got=%h want=%h", NOTE_NUM, 7'h43); end
    endtask

    task automatic test_program();
        send_byte(8'hC0); send_byte(8'hF8); send_byte(8'h05);
        total++; if (PROGRAM !== 7'h05) begin bad++; $display("FAIL pc_prog got=%h want=%h", PROGRAM, 7'h05); end
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL pc_gate got=%b want=%b", GATE, 1'b0); end
        total++; if (NOTE_NUM !== 7'h43) begin bad++; $display("FAIL pc_num got=%h want=%h", NOTE_NUM, 7'h43); end
        send_byte(8'h07);
        total++; if (PROGRAM !== 7'h07) begin bad++; $display("FAIL pc_running got=%h want=%h", PROGRAM, 7'h07); end
        // realtime byte between the two data bytes of a note-on
        send_byte(8'h90); send_byte(8'h30); send_byte(8'hF8); send_byte(8'h64);
        total++; if (NOTE_NUM !== 7'h30) begin bad++; $display("FAIL rt_num got=%h want=%h", NOTE_NUM, 7'h30); end
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL rt_gate got=%b want=%b", GATE, 1'b1); end
        total++; if (PROGRAM !== 7'h07) begin bad++; $display("FAIL rt_prog got=%h want=%h", PROGRAM, 7'h07); end
        send_byte(8'h80); send_byte(8'h30); send_byte(8'h00);
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL rt_off_gate got=%b want=%b", GATE, 1'b0); end
    endtask

    task automatic test_channel_filter();
        snap = stb_cycles;
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        tick();
        total++; if (NOTE_NUM !== 7'h30) begin bad++; $display("FAIL ch_num got=%h want=%h", NOTE_NUM, 7'h30); end
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL ch_gate got=%b want=%b", GATE, 1'b0); end
        total++; if (stb_cycles - snap !== 0) begin bad++; $display("FAIL ch_stb got=%0d want=%0d", stb_cycles - snap, 0); end
        total++; if (o_gate !== 1'b1) begin bad++; $display("FAIL omni_gate got=%b want=%b", o_gate, 1'b1); end
        total++; if (o_num !== 7'h3C) begin bad++; $display("FAIL omni_num got=%h want=%h", o_num, 7'h3C); end
        send_byte(8'h81); send_byte(8'h3C); send_byte(8'h00);
        total++; if (o_gate !== 1'b0) begin bad++; $display("FAIL omni_off got=%b want=%b", o_gate, 1'b0); end
    endtask

    task automatic test_abort();
        snap = stb_cycles;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF0); send_byte(8'h64);
        tick();
        total++; if (NOTE_NUM !== 7'h30) begin bad++; $display("FAIL ab_num got=%h want=%h", NOTE_NUM, 7'h30); end
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL ab_gate got=%b want=%b", GATE, 1'b0); end
        total++; if (stb_cycles - snap !== 0) begin bad++; $display("FAIL ab_stb got=%0d want=%0d", stb_cycles - snap, 0); end
        send_byte(8'h90); send_byte(8'h3C);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total++; if (PROGRAM !== 7'h00) begin bad++; $display("FAIL ab_rst_prog got=%h want=%h", PROGRAM, 7'h00); end
        send_byte(8'h64); send_byte(8'h3C);
        total++; if (NOTE_NUM !== 7'h00) begin bad++; $display("FAIL ab_rst_num got=%h want=%h", NOTE_NUM, 7'h00); end
        total++; if (NOTE_VEL !== 7'h00) begin bad++; $display("FAIL ab_rst_vel got=%h want=%h", NOTE_VEL, 7'h00); end
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL ab_rst_gate got=%b want=%b", GATE, 1'b0); end
    endtask

    task automatic test_ce();
        CE = 1'b0;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        CE = 1'b1;
        send_byte(8'h64);
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL ce_gate got=%b want=%b", GATE, 1'b0); end
        total++; if (NOTE_NUM !== 7'h00) begin bad++; $display("FAIL ce_num got=%h want=%h", NOTE_NUM, 7'h00); end
        send_byte(8'h90); send_byte(8'h45);
        CE = 1'b0;
        send_byte(8'h22);
        CE = 1'b1;
        send_byte(8'h66);
        total++; if (NOTE_NUM !== 7'h45) begin bad++; $display("FAIL ce_mid_num got=%h want=%h", NOTE_NUM, 7'h45); end
        total++; if (NOTE_VEL !== 7'h66) begin bad++; $display("FAIL ce_mid_vel got=%h want=%h", NOTE_VEL, 7'h66); end
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL ce_mid_gate got=%b want=%b", GATE, 1'b1); end
        send_byte(8'h80); send_byte(8'h45); send_byte(8'h00);
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL ce_off_gate got=%b want=%b", GATE, 1'b0); end
    endtask

    task automatic test_back_to_back();
        RX_VALID = 1'b1;
        RX_DATA  = 8'h90; tick();
        RX_DATA  = 8'h2A; tick();
        RX_DATA  = 8'h33; tick();
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        total++; if (NOTE_NUM !== 7'h2A) begin bad++; $display("FAIL b2b_num got=%h want=%h", NOTE_NUM, 7'h2A); end
        total++; if (NOTE_VEL !== 7'h33) begin bad++; $display("FAIL b2b_vel got=%h want=%h", NOTE_VEL, 7'h33); end
        total++; if (NOTE_STB !== 1'b1) begin bad++; $display("FAIL b2b_stb got=%b want=%b", NOTE_STB, 1'b1); end
    endtask

    task automatic test_ignored();
        send_byte(8'hA0); send_byte(8'h2A); send_byte(8'h00);
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL ig_poly_gate got=%b want=%b", GATE, 1'b1); end
        send_byte(8'hD0); send_byte(8'h05);
        total++; if (PROGRAM !== 7'h00) begin bad++; $display("FAIL ig_chpress_prog got=%h want=%h", PROGRAM, 7'h00); end
        send_byte(8'hB0); send_byte(8'h2A); send_byte(8'h00);
        send_byte(8'hE0); send_byte(8'h2A); send_byte(8'h00);
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL ig_cc_bend_gate got=%b want=%b", GATE, 1'b1); end
        total++; if (NOTE_VEL !== 7'h33) begin bad++; $display("FAIL ig_vel got=%h want=%h", NOTE_VEL, 7'h33); end
        send_byte(8'hF0); send_byte(8'h2A); send_byte(8'h00);
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL ig_idle_gate got=%b want=%b", GATE, 1'b1); end
        send_byte(8'h90); send_byte(8'h11); send_byte(8'h00);
        total++; if (GATE !== 1'b1) begin bad++; $display("FAIL ig_v0_other got=%b want=%b", GATE, 1'b1); end
        send_byte(8'h2A); send_byte(8'h00);
        total++; if (GATE !== 1'b0) begin bad++; $display("FAIL ig_v0_same got=%b want=%b", GATE, 1'b0); end
        total++; if (NOTE_NUM !== 7'h2A) begin bad++; $display("FAIL ig_v0_num got=%h want=%h", NOTE_NUM, 7'h2A); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        stb_cycles = 0;
        snap       = 0;
        RST        = 1'b1;
        CE         = 1'b1;
        RX_DATA    = 8'h00;
        RX_VALID   = 1'b0;
        tick();
        test_reset();
        test_note_on();
        test_running_status();
        test_last_note();
        test_program();
        test_channel_filter();
        test_abort();
        test_ce();
        test_back_to_back();
        test_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_parser.md
Name: midi_parser

Overview:
- Byte-level MIDI channel-voice decoder. Sits directly upstream of the nco and drives its NOTE_NUM, NOTE_VEL and PROGRAM inputs.
- Consumes 8-bit bytes from the UART receiver.
- Tracks running status and implements monophonic last-note-priority gating.
- Produces a GATE level and a note-on strobe for the envelope/amp stage.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) this instance responds to.
- OMNI, 0, when 1 respond to all channels and ignore CHANNEL.

Ports:
- CLK  input  1  system clock (100 MHz)
- RST  input  1  asynchronous active-high reset
- CE  input  1  clock enable; when 0, all registers hold and RX_VALID is ignored
- RX_DATA  input  8  received byte; valid only while RX_VALID=1
- RX_VALID  input  1  one-cycle strobe per received byte
- NOTE_NUM  output  7  current note number, to nco
- NOTE_VEL  output  7  current note velocity, to nco
- PROGRAM  output  7  current program (waveform select), to nco
- GATE  output  1  1 while a note is held
- NOTE_STB  output  1  one-cycle pulse on each accepted note-on

Behaviour:
- Reset (async, RST=1):
  - NOTE_NUM, NOTE_VEL, PROGRAM = 0; GATE = 0; NOTE_STB = 0.
  - State = IDLE; running status cleared; data-1 latch = 0.
- A byte is accepted only on a cycle with CE=1 and RX_VALID=1. All outputs are registered and change on the CLK edge that accepts the final byte of a message, so they are visible 1 cycle after that RX_VALID.
- States: IDLE, WAIT_D1, WAIT_D2.
- Realtime bytes (0xF8-0xFF): ignored completely. No change to state, running status or outputs, even mid-message.
- System common bytes (0xF0-0xF7): clear running status; go to IDLE.
- Channel status byte (0x80-0xEF):
  - Store status and channel; go to WAIT_D1. This applies in any state and aborts any partial message.
  - Expected data count: 2 for 0x8n, 0x9n, 0xAn, 0xBn, 0xEn; 1 for 0xCn, 0xDn.
- Data byte (bit7=0):
  - In IDLE: discarded.
  - In WAIT_D1:
    - 2-byte messages: latch the byte, go to WAIT_D2.
    - 1-byte messages: execute, then stay in WAIT_D1 (running status).
  - In WAIT_D2: execute, then go to WAIT_D1 (running status).
- Execute is suppressed (message parsed and discarded) when OMNI=0 and stored channel != CHANNEL, and for status 0xA, 0xB, 0xD, 0xE.
- Execute actions:
  - Note-on 0x9n with vel>0: NOTE_NUM <= d1, NOTE_VEL <= d2, GATE <= 1, NOTE_STB <= 1 for one cycle. Also applies when GATE is already 1 (retrigger / last-note priority).
  - Note-off 0x8n, or 0x9n with vel=0:
    - If GATE=1 and d1==NOTE_NUM: GATE <= 0.
    - Otherwise no change.
    - NOTE_NUM and NOTE_VEL always hold.
  - Program change 0xCn: PROGRAM <= d1. GATE and note outputs are unaffected.
- NOTE_STB is 0 on every cycle other than the cycle following an accepted note-on.
- CE=0 on the cycle a byte arrives: that byte is lost; state unaffected.
- Reset mid-message discards all partial state. Subsequent data bytes are ignored until a new status byte arrives.

Test Plan:
- Reset then bytes 0x90,0x3C,0x64 (CHANNEL=0) -> one cycle after the third strobe: NOTE_NUM=0x3C, NOTE_VEL=0x64, GATE=1, NOTE_STB high exactly 1 cycle.
- Running status: after the above, bytes 0x40,0x50 -> NOTE_NUM=0x40, NOTE_VEL=0x50, GATE=1, second NOTE_STB pulse. Then 0x40,0x00 -> GATE=0, NOTE_NUM stays 0x40.
- Last-note priority: note-on 0x3C, note-on 0x43, then 0x80,0x3C,0x00 -> GATE stays 1, NOTE_NUM=0x43. Then 0x80,0x43,0x00 -> GATE=0.
- Program change and realtime interleave: 0xC0,0xF8,0x05 -> PROGRAM=0x05, state remains WAIT_D1. Then 0x07 -> PROGRAM=0x07.
- Channel filter: CHANNEL=0, OMNI=0, bytes 0x91,0x3C,0x64 -> no output change, NOTE_STB never pulses. Same bytes with OMNI=1 -> GATE=1, NOTE_NUM=0x3C.
- Abort/reset:
  - 0x90,0x3C,0xF0,0x64 -> no output change.
  - 0x90,0x3C then RST pulse, then 0x64,0x3C -> all outputs 0, GATE=0.
  - With CE=0 during 0x90,0x3C,0x64 -> no change.
